sensor_tx_scheduler: RTL
========================

# sensor_tx_scheduler

Frame scheduler that shares the single 8-bit UART transmitter among `N_CH` sensor channels. Picks one requesting channel by round-robin and captures its sample. Sends a 3-byte frame (header, data, checksum) by sequencing the transmitter's `start`/`busy` handshake. Sits between the sensor front-ends (ADC channels) and `uart_tx`, replacing the fixed pace-counter start pulse.

## Interface
Parameters:
- `N_CH`, 4: number of requesting channels (2..8).
- `HDR_BASE`, 8'hA0: header byte base; header = `HDR_BASE | ch` (low 3 bits of `HDR_BASE` must be 0).

Ports:
- `clk`  in  1  single design clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  project enable; when 0 no new grant is issued.
- `req`  in  N_CH  per-channel sample-ready request, level; held until `ack`.
- `data`  in  N_CH*8  channel samples, channel i at bits [8i+7:8i].
- `ack`  out  N_CH  one-hot, one-cycle pulse: sample captured, requester drops/updates `req`.
- `tx_start`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_data`  out  8  byte to transmit; stable from `tx_start` until the next `tx_start`.
- `tx_busy`  in  1  transmitter busy from `uart_tx`.
- `cur_ch`  out  3  channel of the frame in progress (last granted when idle).
- `frame_done`  out  1  one-cycle pulse after the checksum byte finishes.

## Operation
- FSM states: IDLE, LOAD, HDR, HDR_HI, HDR_LO, DAT, DAT_HI, DAT_LO, CHK, CHK_HI, CHK_LO.
- IDLE:
  - If `ena`=1 and any `req` bit is set, the round-robin arbiter grants the first set bit searching from `last+1` (mod N_CH).
  - Register the grant and go to LOAD.
- LOAD:
  - Pulse `ack[grant]`.
  - Capture `data` slice into the sample register.
  - Set `cur_ch` and `last` to the grant.
  - Compute `hdr = HDR_BASE | grant`.
- HDR, DAT, CHK (send states):
  - Wait while `tx_busy`=1.
  - When `tx_busy`=0: pulse `tx_start` and drive `tx_data` with header, sample, or checksum respectively.
  - Advance to the matching `_HI` state.
- `_HI`: wait for `tx_busy`=1, then go to `_LO`.
- `_LO`: wait for `tx_busy`=0.
  - HDR_LO → DAT.
  - DAT_LO → CHK.
  - CHK_LO → IDLE, pulsing `frame_done`.
- Checksum is `hdr ^ sample` (8-bit XOR).
- `ena` falling mid-frame: the frame completes normally, and no new grant is made until `ena`=1.
- `req` changes after grant do not affect the frame in progress. Captured data is used, not live `data`.
- Channel requesting continuously with others idle: granted back-to-back, one frame per grant.

## Timing
- Reset values:
  - `ack`=0, `tx_start`=0, `tx_data`=8'h00, `cur_ch`=0, `frame_done`=0.
  - State IDLE; `last`=N_CH-1, so channel 0 has first priority.
- Reset mid-frame aborts immediately. The transmitter is reset by the same system reset.
- Latency with `tx_busy`=0:
  - `req` seen in IDLE at cycle 0.
  - `ack` at cycle 1 (LOAD).
  - Header `tx_start` at cycle 2.
- Byte spacing: the next `tx_start` comes 1 cycle after `tx_busy` falls (`_LO` → send state → start).
- At most one `tx_start` per byte. `tx_start` is never asserted while `tx_busy`=1.
- `frame_done` is asserted in the cycle the FSM leaves CHK_LO. The earliest next grant evaluation is the following cycle.
- Requirement on the transmitter: `tx_busy` rises within a bounded number of cycles after `tx_start`. `uart_tx` raises it on the next cycle.

## Structure
- Shared package `sensor_hub_pkg` holds:
  - FSM state enum.
  - `FRAME_LEN`=3.
  - `HDR_BASE` default.
  - Checksum function `frame_chk(hdr, sample)`.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs `req`, `last`, `en`; outputs `gnt_valid`, `gnt_idx`.
  - Purely combinational priority rotate.
  - Reusable for future shared resources.
- Top of the sensor hub instantiates the scheduler between the ADC channels and `uart_tx #(DIV(434))`.

## Test plan
- Single channel:
  - Stimulus: `req`=4'b0100, ch2 `data`=8'h5C, `ena`=1, behavioural busy model (busy 10 cycles after start).
  - Required: `ack`=4'b0100 one cycle, then bytes A2, 5C, FE in order.
  - Required: `frame_done` once, `cur_ch`=2.
- Round-robin fairness:
  - Stimulus: `req`=4'b1111 held continuously, samples 10/11/12/13.
  - Required: grant order ch0, ch1, ch2, ch3, ch0.
  - Required: headers A0, A1, A2, A3, A0; each checksum = hdr^data.
- Handshake compliance:
  - Stimulus: busy model delays `tx_busy` rise by 3 cycles and holds high 434*10 cycles.
  - Required: no `tx_start` while busy; exactly 3 starts per frame; next start 1 cycle after busy falls.
- Enable gating:
  - Stimulus: drop `ena` during the DAT byte.
  - Required: the frame completes; no `ack` while `ena`=0; a pending `req` is granted 1 cycle after `ena` returns.
- Reset mid-frame:
  - Stimulus: assert `rst` in CHK_HI.
  - Required: all outputs 0 immediately; after release, `req`=4'b1000 with ch3 `data`=8'h00 gives bytes A3, 00, A3.

Source files
------------

// File: rtl/sensor_hub_pkg.sv
// rtl/sensor_hub_pkg.sv - shared FSM states, frame constants and checksum for the sensor hub
package sensor_hub_pkg;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      HDR,
      HDR_HI,
      HDR_LO,
      DAT,
      DAT_HI,
      DAT_LO,
      CHK,
      CHK_HI,
      CHK_LO
   } sched_state_t;

   localparam int         FRAME_LEN        = 3;
   localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

   function automatic logic [7:0] frame_chk(input logic [7:0] hdr, input logic [7:0] sample);
      return hdr ^ sample;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, searches from last+1 upward (mod N)
module rr_arbiter #(
   parameter int  N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   input  logic          en,
   output logic          gnt_valid,
   output logic [IW-1:0] gnt_idx
);

   logic [N-1:0] rot;

   always_comb begin
      // rot[k] is the request of channel (last+1+k) mod N
      rot       = N'({req, req} >> (int'(last) + 1));
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (en && rot[k]) begin
            gnt_valid = 1'b1;
            gnt_idx   = IW'((int'(last) + 1 + k) % N);
         end
      end
   end

endmodule

// File: rtl/sensor_tx_scheduler.sv
// rtl/sensor_tx_scheduler.sv - shares one UART transmitter among N_CH sensor channels,
// sending header/sample/checksum frames over the tx_start/tx_busy handshake
module sensor_tx_scheduler
   import sensor_hub_pkg::*;
#(
   parameter int         N_CH     = 4,
   parameter logic [7:0] HDR_BASE = HDR_BASE_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic [N_CH-1:0]   req,
   input  logic [N_CH*8-1:0] data,
   output logic [N_CH-1:0]   ack,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic [2:0]        cur_ch,
   output logic              frame_done
);

   localparam int IW = $clog2(N_CH);

   sched_state_t  state_q, state_d;
   logic [IW-1:0] grant_q, grant_d;
   logic [IW-1:0] last_q, last_d;
   logic [2:0]    cur_ch_q, cur_ch_d;
   logic [7:0]    sample_q, sample_d;
   logic [7:0]    hdr_q, hdr_d;
   logic [7:0]    tx_data_q, tx_data_d;

   logic          gnt_valid;
   logic [IW-1:0] gnt_idx;

   rr_arbiter #(.N(N_CH)) u_arb (
      .req       (req),
      .last      (last_q),
      .en        (ena && (state_q == IDLE)),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         last_q    <= IW'(N_CH - 1);
         cur_ch_q  <= '0;
         sample_q  <= '0;
         hdr_q     <= '0;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         cur_ch_q  <= cur_ch_d;
         sample_q  <= sample_d;
         hdr_q     <= hdr_d;
         tx_data_q <= tx_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      cur_ch_d   = cur_ch_q;
      sample_d   = sample_q;
      hdr_d      = hdr_q;
      tx_data_d  = tx_data_q;
      ack        = '0;
      tx_start   = 1'b0;
      frame_done = 1'b0;
      // the byte being started is presented in the same cycle, then held in tx_data_q
      tx_data    = tx_data_q;

      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               grant_d = gnt_idx;
               state_d = LOAD;
            end
         end
         LOAD: begin
            for (int i = 0; i < N_CH; i++) begin
               if (grant_q == IW'(i)) begin
                  ack[i]   = 1'b1;
                  sample_d = data[8*i +: 8];
               end
            end
            cur_ch_d = 3'(grant_q);
            last_d   = grant_q;
            hdr_d    = HDR_BASE | 8'(grant_q);
            state_d  = HDR;
         end
         HDR, DAT, CHK: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               if (state_q == HDR) begin
                  tx_data = hdr_q;
                  state_d = HDR_HI;
               end else if (state_q == DAT) begin
                  tx_data = sample_q;
                  state_d = DAT_HI;
               end else begin
                  tx_data = frame_chk(hdr_q, sample_q);
                  state_d = CHK_HI;
               end
               tx_data_d = tx_data;
            end
         end
         HDR_HI: if (tx_busy) state_d = HDR_LO;
         DAT_HI: if (tx_busy) state_d = DAT_LO;
         CHK_HI: if (tx_busy) state_d = CHK_LO;
         HDR_LO: if (!tx_busy) state_d = DAT;
         DAT_LO: if (!tx_busy) state_d = CHK;
         CHK_LO: begin
            if (!tx_busy) begin
               frame_done = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cur_ch = cur_ch_q;

endmodule
